spi_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` register port between `N_REQ` requesters, for example the I2C-slave bridge and the local configuration engine. For each granted request it performs one complete two-byte SPI transaction:

- writes the data, address and control registers,
- polls the control register until the start bit clears,
- reads back the received byte and returns it to the requester with a done pulse.

---
 rtl/spi_arb_pkg.sv | 37 +++
 rtl/spi_req_arbiter_rr_pick.sv | 34 +++
 rtl/spi_req_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg -- shared definitions for spi_req_arbiter.
//   * FSM state encoding (4-bit, legacy-compatible localparams)
//   * spi_master register addresses (CTRL, TXD, TXA, RXD)
//   * control register bit positions (START, LSB)
//   * ctrl_byte(): builds the control word that launches a transfer
// Optional feature macro used by the top: SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_DATA   = 4'd1;
  localparam logic [3:0] S_WR_ADDR   = 4'd2;
  localparam logic [3:0] S_WR_CTRL   = 4'd3;
  localparam logic [3:0] S_POLL_WAIT = 4'd4;
  localparam logic [3:0] S_POLL_RD   = 4'd5;
  localparam logic [3:0] S_POLL_CHK  = 4'd6;
  localparam logic [3:0] S_RX_RD     = 4'd7;
  localparam logic [3:0] S_RX_CAP    = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_ABORT     = 4'd10;

  localparam logic [3:0] CTRL = 4'd0;
  localparam logic [3:0] TXD  = 4'd1;
  localparam logic [3:0] TXA  = 4'd2;
  localparam logic [3:0] RXD  = 4'd3;

  localparam int START = 0;
  localparam int LSB   = 3;

  function automatic logic [7:0] ctrl_byte(input logic lsb);
    logic [7:0] b;
    b        = '0;
    b[START] = 1'b1;
    b[LSB]   = lsb;
    return b;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker.
// Ports:
//   req  : request vector
//   last : index of the last-served requester; search starts at last+1
//   gnt  : one-hot grant of the first requester found (0 when none)
//   vld  : 1 when any request is pending
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDXW  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);

  always_comb begin
    int j;
    gnt = '0;
    vld = 1'b0;
    j   = 0;
    // Walk N_REQ positions starting just after 'last', wrapping once;
    // the last position visited is 'last' itself.
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(last) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!vld && req[IDXW'(j)]) begin
        gnt[IDXW'(j)] = 1'b1;
        vld           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter -- shares one spi_master register port between N_REQ
// requesters. Each grant runs one full transaction: write TX data, TX
// address and control, poll control until start clears, read RX data and
// return it with a one-cycle done pulse.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort after TIMEOUT_POLLS
// busy polls (o_err then flags the done pulse); otherwise polling is endless.
// Ports:
//   i_ck, i_rstn           clock, async active-low reset
//   i_req/_addr/_data/_lsb per-requester request and operands (8-bit lanes)
//   o_gnt, o_done          one-hot grant, one-cycle completion pulse
//   o_rdata, o_err         received byte, timeout flag (with o_done)
//   o_address, o_wdata,
//   o_wr, o_rd, i_rdata    spi_master register port
//   o_dbg_state            current FSM state for observation
// Handshake: a requester holds i_req and operands until o_done; operands are
// latched at grant, and a grant always runs to its o_done pulse.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int POLL_GAP      = 8,
  parameter int TIMEOUT_POLLS = 255
) (
  input  logic               i_ck,
  input  logic               i_rstn,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_addr,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_lsb,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [7:0]         o_rdata,
  output logic               o_err,
  output logic [3:0]         o_address,
  output logic [7:0]         o_wdata,
  input  logic [7:0]         i_rdata,
  output logic               o_wr,
  output logic               o_rd,
  output logic [3:0]         o_dbg_state
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_REQ - 1);
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  if (N_REQ < 2 || N_REQ > 8 || POLL_GAP < 1 || POLL_GAP > 255 ||
      TIMEOUT_POLLS < 1 || TIMEOUT_POLLS > 255) begin : g_param_check
    $error("spi_req_arbiter: parameter out of range");
  end

  logic [3:0]       state;
  logic [IDXW-1:0]  last_idx;
  logic [IDXW-1:0]  cur_idx;
  logic [7:0]       lat_addr;
  logic [7:0]       lat_data;
  logic             lat_lsb;
  logic [7:0]       gap_cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_vld;
  logic [IDXW-1:0]  pick_idx;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_data;
  logic             sel_lsb;

  rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
    .req  (i_req),
    .last (last_idx),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  // Operand mux for the requester the picker selected.
  always_comb begin
    pick_idx = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_lsb  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        pick_idx = IDXW'(k);
        sel_addr = i_req_addr[8*k +: 8];
        sel_data = i_req_data[8*k +: 8];
        sel_lsb  = i_req_lsb[k];
      end
    end
  end

  assign o_dbg_state = state;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_POLLS - 1);
  logic [7:0] poll_cnt;
`else
  assign o_err = 1'b0;
`endif

  // Every master-port output is registered and loaded on the transition
  // into the state that owns it, so strobes are high exactly while the FSM
  // sits in that state and address/data hold between strobes.
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      last_idx  <= LAST_RST;
      cur_idx   <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_lsb   <= 1'b0;
      gap_cnt   <= '0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_rdata   <= '0;
      o_address <= '0;
      o_wdata   <= '0;
      o_wr      <= 1'b0;
      o_rd      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_err     <= 1'b0;
      poll_cnt  <= '0;
`endif
    end else begin
      o_wr   <= 1'b0;
      o_rd   <= 1'b0;
      o_done <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      o_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            o_gnt     <= pick_gnt;
            cur_idx   <= pick_idx;
            lat_addr  <= sel_addr;
            lat_data  <= sel_data;
            lat_lsb   <= sel_lsb;
            o_wr      <= 1'b1;
            o_address <= TXD;
            o_wdata   <= sel_data;
`ifdef SPI_ARB_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
            state     <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          o_wr      <= 1'b1;
          o_address <= TXA;
          o_wdata   <= lat_addr;
          state     <= S_WR_ADDR;
        end
        S_WR_ADDR: begin
          o_wr      <= 1'b1;
          o_address <= CTRL;
          o_wdata   <= ctrl_byte(lat_lsb);
          state     <= S_WR_CTRL;
        end
        S_WR_CTRL: begin
          gap_cnt <= '0;
          state   <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            o_rd      <= 1'b1;
            o_address <= CTRL;
            state     <= S_POLL_RD;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_POLL_RD: state <= S_POLL_CHK;
        S_POLL_CHK: begin
          if (i_rdata[START]) begin
`ifdef SPI_ARB_TIMEOUT_EN
            if (poll_cnt == TO_LAST) begin
              // Clear the master's start bit before reporting the abort.
              o_wr      <= 1'b1;
              o_address <= CTRL;
              o_wdata   <= 8'h00;
              state     <= S_ABORT;
            end else begin
              poll_cnt <= poll_cnt + 8'd1;
              gap_cnt  <= '0;
              state    <= S_POLL_WAIT;
            end
`else
            gap_cnt <= '0;
            state   <= S_POLL_WAIT;
`endif
          end else begin
            o_rd      <= 1'b1;
            o_address <= RXD;
            state     <= S_RX_RD;
          end
        end
        S_RX_RD: state <= S_RX_CAP;
        S_RX_CAP: begin
          o_rdata <= i_rdata;
          o_done  <= o_gnt;
          state   <= S_DONE;
        end
        S_DONE: begin
          o_gnt    <= '0;
          last_idx <= cur_idx;
          state    <= S_IDLE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        S_ABORT: begin
          o_done <= o_gnt;
          o_err  <= 1'b1;
          state  <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter -- directed bench for spi_req_arbiter with a small
// behavioural spi_master model that logs every write and read strobe.
module tb_spi_req_arbiter;
  import spi_arb_pkg::*;

  localparam int N_REQ    = 2;
  localparam int POLL_GAP = 3;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_POLLS = 4;
`else
  localparam int TO_POLLS = 255;
`endif

  logic               i_ck;
  logic               i_rstn;
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_req_addr;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_lsb;
  logic [N_REQ-1:0]   o_gnt;
  logic [N_REQ-1:0]   o_done;
  logic [7:0]         o_rdata;
  logic               o_err;
  logic [3:0]         o_address;
  logic [7:0]         o_wdata;
  logic [7:0]         i_rdata;
  logic               o_wr;
  logic               o_rd;
  logic [3:0]         o_dbg_state;

  int checks   = 0;
  int failures = 0;

  // master model configuration (set by tests) and logs (written by model)
  int         busy_until  = 0;
  logic       stick_busy  = 1'b0;
  logic [7:0] rx_cfg      = 8'h00;
  int         status_reads = 0;
  logic [11:0] wr_log[$];
  logic [3:0]  rd_log[$];
  logic [11:0] exp_q[$];
  logic [3:0]  exp_rd[$];

  spi_req_arbiter #(.N_REQ(N_REQ), .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TO_POLLS)) dut (
    .i_ck        (i_ck),
    .i_rstn      (i_rstn),
    .i_req       (i_req),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .i_req_lsb   (i_req_lsb),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_address   (o_address),
    .o_wdata     (o_wdata),
    .i_rdata     (i_rdata),
    .o_wr        (o_wr),
    .o_rd        (o_rd),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_ck = 1'b0;
  always #5 i_ck = ~i_ck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- spi_master model ----------------
  always @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      i_rdata <= 8'h00;
    end else begin
      if (o_wr) wr_log.push_back({o_address, o_wdata});
      if (o_rd) begin
        rd_log.push_back(o_address);
        if (o_address == CTRL) begin
          i_rdata <= (stick_busy || status_reads < busy_until) ? 8'h01 : 8'h00;
          status_reads++;
        end else begin
          i_rdata <= rx_cfg;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge i_ck);
    i_rstn = 1'b0;
    repeat (2) @(negedge i_ck);
    i_rstn = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc, inout int cyc, output logic ok);
    ok = 1'b0;
    while (cyc < max_cyc && !ok) begin
      @(negedge i_ck);
      cyc++;
      if (o_done !== '0) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rstn = 1'b0;
    i_req = '0; i_req_addr = '0; i_req_data = '0; i_req_lsb = '0;
    repeat (2) @(negedge i_ck);
    checks++;
    if ({o_gnt, o_done, o_rdata, o_err, o_address, o_wdata, o_wr, o_rd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h err=%b addr=%h wdata=%h wr=%b rd=%b want all 0",
               o_gnt, o_done, o_rdata, o_err, o_address, o_wdata, o_wr, o_rd);
    end
    checks++;
    if (o_dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want %0d", o_dbg_state, S_IDLE);
    end
    i_rstn = 1'b1;
  endtask

  task automatic test_single();
    int wb, rb, cyc;
    logic ok;
    @(negedge i_ck);
    wb = wr_log.size(); rb = rd_log.size();
    busy_until = status_reads + 3;
    rx_cfg = 8'h5A;
    i_req_addr[7:0] = 8'hA5; i_req_data[7:0] = 8'h3C; i_req_lsb[0] = 1'b0;
    i_req = 2'b01;
    cyc = 0;
    @(negedge i_ck); cyc++;
    checks++;
    if (o_wr !== 1'b1 || o_address !== TXD || o_gnt !== 2'b01) begin
      failures++;
      $display("FAIL single_first_wr: got wr=%b addr=%h gnt=%b want wr=1 addr=1 gnt=01", o_wr, o_address, o_gnt);
    end
    wait_done(200, cyc, ok);
    i_req = '0;
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL single_done_timeout: no o_done within %0d cycles", cyc);
    end
    checks++;
    if (o_done !== 2'b01 || o_rdata !== 8'h5A || o_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got done=%b rdata=%h err=%b want done=01 rdata=5a err=0", o_done, o_rdata, o_err);
    end
    checks++;
    if (cyc !== 26) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles want 26", cyc);
    end
    exp_q = '{12'h13C, 12'h2A5, 12'h001};
    checks++;
    if (wr_log.size() - wb !== exp_q.size()) begin
      failures++;
      $display("FAIL single_wr_count: got %0d want %0d", wr_log.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [11:0] got;
      got = (wb + i < wr_log.size()) ? wr_log[wb + i] : 12'hxxx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL single_wr%0d: got addr/data %h want %h", i, got, exp_q[i]);
      end
    end
    exp_rd = '{CTRL, CTRL, CTRL, CTRL, RXD};
    checks++;
    if (rd_log.size() - rb !== exp_rd.size()) begin
      failures++;
      $display("FAIL single_rd_count: got %0d want %0d", rd_log.size() - rb, exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size(); i++) begin
      logic [3:0] got;
      got = (rb + i < rd_log.size()) ? rd_log[rb + i] : 4'hx;
      checks++;
      if (got !== exp_rd[i]) begin
        failures++;
        $display("FAIL single_rd%0d: got addr %h want %h", i, got, exp_rd[i]);
      end
    end
  endtask

  task automatic test_lsb();
    int wb, cyc;
    logic ok;
    @(negedge i_ck);
    wb = wr_log.size();
    busy_until = status_reads;
    rx_cfg = 8'hC3;
    i_req_addr[15:8] = 8'h11; i_req_data[15:8] = 8'h22; i_req_lsb[1] = 1'b1;
    i_req = 2'b10;
    cyc = 0;
    wait_done(100, cyc, ok);
    i_req = '0;
    checks++;
    if (ok !== 1'b1 || o_done !== 2'b10 || o_rdata !== 8'hC3) begin
      failures++;
      $display("FAIL lsb_result: got ok=%b done=%b rdata=%h want ok=1 done=10 rdata=c3", ok, o_done, o_rdata);
    end
    checks++;
    if (cyc !== 11) begin
      failures++;
      $display("FAIL lsb_latency: got %0d cycles want 11", cyc);
    end
    exp_q = '{12'h122, 12'h211, 12'h009};
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [11:0] got;
      got = (wb + i < wr_log.size()) ? wr_log[wb + i] : 12'hxxx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL lsb_wr%0d: got addr/data %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [N_REQ-1:0] exp_g;
    logic ok;
    int cyc;
    busy_until = status_reads;
    rx_cfg = 8'h66;
    i_req_lsb = '0;
    @(negedge i_ck);
    i_rstn = 1'b0;
    i_req = 2'b11;
    repeat (2) @(negedge i_ck);
    i_rstn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      cyc = 0;
      wait_done(100, cyc, ok);
      checks++;
      if (ok !== 1'b1 || o_done !== exp_g || o_gnt !== exp_g) begin
        failures++;
        $display("FAIL fair_order%0d: got ok=%b done=%b gnt=%b want done=%b", t, ok, o_done, o_gnt, exp_g);
      end
      if (t == 0) begin
        @(negedge i_ck);
        checks++;
        if (o_gnt !== 2'b00 || o_dbg_state !== S_IDLE) begin
          failures++;
          $display("FAIL b2b_idle: got gnt=%b state=%0d want gnt=00 state=%0d", o_gnt, o_dbg_state, S_IDLE);
        end
        @(negedge i_ck);
        checks++;
        if (o_gnt !== 2'b10 || o_wr !== 1'b1) begin
          failures++;
          $display("FAIL b2b_regrant: got gnt=%b wr=%b want gnt=10 wr=1", o_gnt, o_wr);
        end
      end
    end
    i_req = '0;
  endtask

  task automatic test_operand_stability();
    int wb, cyc;
    logic ok;
    @(negedge i_ck);
    @(negedge i_ck);
    wb = wr_log.size();
    busy_until = status_reads + 1;
    rx_cfg = 8'h81;
    i_req_addr[7:0] = 8'h10; i_req_data[7:0] = 8'h77; i_req_lsb[0] = 1'b0;
    i_req = 2'b01;
    cyc = 0;
    @(negedge i_ck); cyc++;
    // change operands and drop the request once granted
    i_req_addr[7:0] = 8'hEE; i_req_data[7:0] = 8'h88; i_req_lsb[0] = 1'b1;
    i_req = 2'b00;
    wait_done(100, cyc, ok);
    checks++;
    if (ok !== 1'b1 || o_done !== 2'b01 || o_rdata !== 8'h81) begin
      failures++;
      $display("FAIL stable_done: got ok=%b done=%b rdata=%h want ok=1 done=01 rdata=81", ok, o_done, o_rdata);
    end
    exp_q = '{12'h177, 12'h210, 12'h001};
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [11:0] got;
      got = (wb + i < wr_log.size()) ? wr_log[wb + i] : 12'hxxx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL stable_wr%0d: got addr/data %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_poll();
    int wb, cyc;
    logic ok;
    @(negedge i_ck);
    busy_until = status_reads + 100;
    rx_cfg = 8'h3E;
    i_req_addr[7:0] = 8'h42; i_req_data[7:0] = 8'h24; i_req_lsb[0] = 1'b0;
    i_req = 2'b01;
    cyc = 0;
    while (cyc < 20 && o_dbg_state !== S_POLL_WAIT) begin
      @(negedge i_ck);
      cyc++;
    end
    checks++;
    if (o_dbg_state !== S_POLL_WAIT) begin
      failures++;
      $display("FAIL midpoll_reach: got state %0d want %0d", o_dbg_state, S_POLL_WAIT);
    end
    i_rstn = 1'b0;
    #1;
    checks++;
    if ({o_gnt, o_done, o_rdata, o_err, o_address, o_wdata, o_wr, o_rd} !== '0) begin
      failures++;
      $display("FAIL midpoll_reset_outputs: got gnt=%b rdata=%h addr=%h wdata=%h wr=%b rd=%b want all 0",
               o_gnt, o_rdata, o_address, o_wdata, o_wr, o_rd);
    end
    @(negedge i_ck);
    busy_until = status_reads;
    wb = wr_log.size();
    i_rstn = 1'b1;
    cyc = 0;
    @(negedge i_ck); cyc++;
    checks++;
    if (o_wr !== 1'b1 || o_address !== TXD || o_wdata !== 8'h24 || o_gnt !== 2'b01) begin
      failures++;
      $display("FAIL midpoll_restart: got wr=%b addr=%h wdata=%h gnt=%b want wr=1 addr=1 wdata=24 gnt=01",
               o_wr, o_address, o_wdata, o_gnt);
    end
    wait_done(100, cyc, ok);
    i_req = '0;
    checks++;
    if (ok !== 1'b1 || o_rdata !== 8'h3E || wr_log.size() - wb !== 3) begin
      failures++;
      $display("FAIL midpoll_done: got ok=%b rdata=%h writes=%0d want ok=1 rdata=3e writes=3",
               ok, o_rdata, wr_log.size() - wb);
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int wb, rb, cyc;
    logic ok;
    @(negedge i_ck);
    @(negedge i_ck);
    wb = wr_log.size(); rb = rd_log.size();
    stick_busy = 1'b1;
    rx_cfg = 8'hF0;
    i_req_addr[15:8] = 8'h55; i_req_data[15:8] = 8'h66; i_req_lsb[1] = 1'b0;
    i_req = 2'b10;
    cyc = 0;
    wait_done(200, cyc, ok);
    i_req = '0;
    stick_busy = 1'b0;
    checks++;
    if (ok !== 1'b1 || o_done !== 2'b10 || o_err !== 1'b1 || o_rdata !== 8'h3E) begin
      failures++;
      $display("FAIL timeout_done: got ok=%b done=%b err=%b rdata=%h want ok=1 done=10 err=1 rdata=3e",
               ok, o_done, o_err, o_rdata);
    end
    exp_rd = '{CTRL, CTRL, CTRL, CTRL};
    checks++;
    if (rd_log.size() - rb !== exp_rd.size()) begin
      failures++;
      $display("FAIL timeout_rd_count: got %0d want %0d", rd_log.size() - rb, exp_rd.size());
    end
    exp_q = '{12'h166, 12'h255, 12'h001, 12'h000};
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [11:0] got;
      got = (wb + i < wr_log.size()) ? wr_log[wb + i] : 12'hxxx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL timeout_wr%0d: got addr/data %h want %h", i, got, exp_q[i]);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_lsb();
    test_fairness();
    test_operand_stability();
    test_reset_mid_poll();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge i_ck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
